// File: rtl/sseg_share.sv
// sseg_share: round-robin time-sharing of one 4-digit seven-segment display among NREQ requesters
module sseg_share #(
    parameter int NREQ  = 4,
    parameter int W     = 16,
    parameter int DWELL = 10000000,
    parameter int CW    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data,
    input  logic              lock,
    output logic [NREQ-1:0]   grant,
    output logic [2:0]        owner,
    output logic              active,
    output logic [W-1:0]      value_out
);
    typedef enum logic {IDLE, SHOW} state_t;
    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      value_q, value_d;
    logic [W-1:0]      words [8];
    logic [7:0]        req8;
    logic [3:0]        pk;
    logic              take;
    // Returns {found, index} of the first set request strictly after base, wrapping around.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] j;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = 3'((int'(base) + k) % NREQ);
            if (r[j]) res = {1'b1, j};
        end
        return res;
    endfunction
    for (genvar i = 0; i < 8; i++) begin : g_w
        if (i < NREQ) begin : g_u
            assign words[i] = data[i*W +: W];
        end else begin : g_z
            assign words[i] = '0;
        end
    end
    assign req8 = 8'(req);
    // A new owner is chosen from idle, when the owner lets go (even under lock), or when its dwell runs out.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        pk      = pick(req8, state_q == IDLE ? last_q : owner_q);
        take    = state_q == IDLE || !req8[owner_q] || (!lock && cnt_q == '0);
        if (take) begin
            state_d = pk[3] ? SHOW : IDLE;
            grant_d = pk[3] ? NREQ'(1) << pk[2:0] : '0;
            owner_d = pk[3] ? pk[2:0] : owner_q;
            last_d  = pk[3] ? pk[2:0] : last_q;
            cnt_d   = pk[3] ? CW'(DWELL - 1) : cnt_q;
            value_d = pk[3] ? words[pk[2:0]] : '0;
        end else begin
            cnt_d   = lock ? cnt_q : cnt_q - 1'b1;
            value_d = words[owner_q];
        end
    end
    // All outputs are registered together; reset favours requester 0 by parking the pointer at NREQ-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= 3'(NREQ - 1);
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end
    assign grant     = grant_q;
    assign owner     = owner_q;
    assign active    = state_q == SHOW;
    assign value_out = value_q;
endmodule

// File: tb/tb_sseg_share.sv
// tb_sseg_share: directed table plus randomized model checking of sseg_share at DWELL=4 and DWELL=1
module tb_sseg_share;
    localparam int NREQ = 4;
    localparam int W    = 16;
    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic              lock;
    logic [NREQ-1:0]   g4, g1;
    logic [2:0]        o4, o1;
    logic              a4, a1;
    logic [W-1:0]      v4, v1;
    int checks = 0;
    int errors = 0;
    int m_own [2];
    int m_rem [2];
    int m_last [2];
    int dw [2] = '{4, 1};
    logic [W-1:0] m_val [2];

    sseg_share #(.NREQ(NREQ), .W(W), .DWELL(4), .CW(8)) dut4 (
        .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock),
        .grant(g4), .owner(o4), .active(a4), .value_out(v4)
    );
    sseg_share #(.NREQ(NREQ), .W(W), .DWELL(1), .CW(4)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock),
        .grant(g1), .owner(o1), .active(a1), .value_out(v1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int srch(input logic [NREQ-1:0] r, input int base);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(base + k) % NREQ]) return (base + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i]  = -1;
            m_rem[i]  = 0;
            m_last[i] = NREQ - 1;
            m_val[i]  = '0;
        end
    endtask

    task automatic m_step();
        int p;
        for (int i = 0; i < 2; i++) begin
            if (m_own[i] < 0 || !req[m_own[i]] || (!lock && m_rem[i] == 0)) begin
                p = srch(req, m_own[i] < 0 ? m_last[i] : m_own[i]);
                m_own[i] = p;
                if (p >= 0) begin
                    m_last[i] = p;
                    m_rem[i]  = dw[i] - 1;
                end
            end else if (!lock) begin
                m_rem[i]--;
            end
            m_val[i] = m_own[i] < 0 ? '0 : data[m_own[i]*W +: W];
        end
    endtask

    task automatic cmp_model();
        chk("m4_grant", 32'(g4), m_own[0] < 0 ? 0 : 1 << m_own[0]);
        chk("m4_active", 32'(a4), m_own[0] >= 0);
        chk("m4_value", 32'(v4), 32'(m_val[0]));
        if (m_own[0] >= 0) chk("m4_owner", 32'(o4), m_own[0]);
        chk("m1_grant", 32'(g1), m_own[1] < 0 ? 0 : 1 << m_own[1]);
        chk("m1_active", 32'(a1), m_own[1] >= 0);
        chk("m1_value", 32'(v1), 32'(m_val[1]));
        if (m_own[1] >= 0) chk("m1_owner", 32'(o1), m_own[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_grant", 32'(g4 | g1), 0);
        chk("rst_active", 32'(a4 | a1), 0);
        chk("rst_value", 32'(v4 | v1), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic            lock;
        int              reps;
        logic [NREQ-1:0] g;
        logic [W-1:0]    v;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl = '{
            '{4'b0101, 1'b0, 4,  4'b0001, 16'hA0A0},
            '{4'b0101, 1'b0, 4,  4'b0100, 16'hC2C2},
            '{4'b0101, 1'b0, 1,  4'b0001, 16'hA0A0},
            '{4'b0001, 1'b0, 1,  4'b0001, 16'hA0A0},
            '{4'b0101, 1'b0, 2,  4'b0001, 16'hA0A0},
            '{4'b0101, 1'b0, 1,  4'b0100, 16'hC2C2},
            '{4'b1101, 1'b0, 1,  4'b0100, 16'hC2C2},
            '{4'b1001, 1'b0, 1,  4'b1000, 16'hD3D3},
            '{4'b0000, 1'b0, 1,  4'b0000, 16'h0000},
            '{4'b0011, 1'b0, 1,  4'b0001, 16'hA0A0},
            '{4'b0011, 1'b1, 20, 4'b0001, 16'hA0A0},
            '{4'b0011, 1'b0, 3,  4'b0001, 16'hA0A0},
            '{4'b0011, 1'b0, 1,  4'b0010, 16'hB1B1},
            '{4'b0011, 1'b1, 1,  4'b0010, 16'hB1B1},
            '{4'b0001, 1'b1, 1,  4'b0001, 16'hA0A0},
            '{4'b0000, 1'b0, 1,  4'b0000, 16'h0000}
        };
        rst  = 1'b1;
        req  = '0;
        lock = 1'b0;
        data = '0;
        m_reset();
        #2;
        chk("por_grant", 32'(g4), 0);
        chk("por_active", 32'(a4), 0);
        chk("por_value", 32'(v4), 0);
        #10;
        rst = 1'b0;
        // single requester, live data tracking
        req  = 4'b0001;
        data = 64'h0000_0000_0000_BEEF;
        tick();
        chk("t1_grant", 32'(g4), 32'h1);
        chk("t1_active", 32'(a4), 32'h1);
        chk("t1_value", 32'(v4), 32'hBEEF);
        data[15:0] = 16'h1234;
        tick();
        chk("t1_track", 32'(v4), 32'h1234);
        do_reset();
        // directed table, DWELL=4
        data = 64'hD3D3_C2C2_B1B1_A0A0;
        foreach (tbl[r]) begin
            for (int n = 0; n < tbl[r].reps; n++) begin
                req  = tbl[r].req;
                lock = tbl[r].lock;
                tick();
                chk($sformatf("tbl%0d_grant", r), 32'(g4), 32'(tbl[r].g));
                chk($sformatf("tbl%0d_value", r), 32'(v4), 32'(tbl[r].v));
                chk($sformatf("tbl%0d_active", r), 32'(a4), 32'(|tbl[r].g));
            end
        end
        // asynchronous reset in the middle of a SHOW cycle
        req  = 4'b0110;
        lock = 1'b0;
        tick();
        tick();
        chk("ar_pre_active", 32'(a4), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_grant", 32'(g4), 0);
        chk("ar_active", 32'(a4), 0);
        chk("ar_value", 32'(v4), 0);
        m_reset();
        #1;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("ar_first", 32'(g4), 32'h1);
        chk("ar_first1", 32'(g1), 32'h1);
        tick();
        chk("ar_rot1", 32'(g1), 32'h2);
        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NREQ-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) lock = ~lock;
            data = {$urandom, $urandom};
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sseg_share.md
Name: sseg_share

Overview:
- Time-shares the single 4-digit seven-segment display between NREQ requesters, e.g. switch echo, CPU debug register, PC, fault code.
- Each requester holds `req` high while it wants the display.
- When several requesters are active, the block grants them round-robin, each for DWELL clock cycles.
- Its `value_out` drives the `in` port of the sseg display driver. It sits in the top level on the 10 MHz clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, display word width (4 hex digits)
- DWELL, 10000000, cycles per turn when others are waiting (1 s at 10 MHz); must be ≥1
- CW, 24, dwell counter width; must satisfy 2^CW > DWELL

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  asynchronous active-high reset
- req  in  NREQ  request per requester; level, held while the display is wanted
- data  in  NREQ*W  display words; requester i occupies bits [i*W +: W]
- lock  in  1  high = freeze rotation on the current owner
- grant  out  NREQ  one-hot owner; all zero when idle
- owner  out  3  binary index of the current owner; valid only when `active`=1
- active  out  1  1 = a requester owns the display
- value_out  out  W  word to display; 0 when idle

Behaviour:
- Reset is asynchronous, active-high and applies immediately:
  - grant=0, owner=0, active=0, value_out=0.
  - Dwell counter = 0.
  - Round-robin pointer `last` = NREQ-1, so requester 0 wins first.
- States:
  - IDLE: active=0.
  - SHOW: active=1.
- All outputs are registered and update on the same edge.
- value_out <= data slice of the next-cycle owner, so value_out follows live data with a 1-cycle latency, aligned with grant.
- Round-robin pick: search indices (last+1) … (last+NREQ) mod NREQ and take the first index with req set.
- IDLE:
  - If any req is set: pick, enter SHOW, grant the pick, set last=pick, load counter=DWELL-1.
  - Latency from req rising to grant is 1 cycle.
  - If no req is set: stay in IDLE; value_out=0.
- SHOW, evaluated in this priority order:
  1. req[owner] low: re-pick immediately, searching from owner+1 (lock is ignored).
     - Some requester found: new owner, counter reloads.
     - None found: go to IDLE; grant=0, value_out=0 on that edge.
  2. lock high: hold owner; counter holds its value (frozen).
  3. counter > 0: decrement.
  4. counter = 0:
     - Pick searching from owner+1. The pick may equal owner when nobody else requests.
     - Grant the pick and reload counter=DWELL-1.
     - Re-granting the same owner is glitch-free: grant and value_out are unchanged apart from data tracking.
- Simultaneous events:
  - Owner drops req on the same cycle the counter expires: rule 1 applies.
  - A new req arriving mid-dwell does not preempt; it waits for expiry.
- lock falling: counting resumes from the frozen value.
- DWELL=1: counter stays 0, so the owner rotates every cycle among active requesters.
- req bits of non-owners may toggle freely. Only their level at pick time matters.
- grant is always one-hot or zero; it is never multi-hot.
- Reset asserted in mid-SHOW returns to the reset state on the spot. After release, requester 0 is favoured again.

Test Plan:
- Reset, then req=0001, data0=0xBEEF:
  - next edge grant=0001, active=1, value_out=0xBEEF.
  - data0 changes to 0x1234 → value_out=0x1234 one cycle later.
- DWELL=4, req=0101 both held from IDLE:
  - grant=0001 for 4 cycles, then 0100 for 4 cycles, then 0001.
  - At every switch, value_out changes on the same edge as grant.
- DWELL=4, owner=0, req=0001; req2 rises mid-dwell:
  - no preemption; grant moves to 0100 exactly at the expiry edge.
  - req0 alone past expiry → grant stays 0001 with no gap.
- Owner 2 drops req mid-dwell with req=1001 remaining:
  - next edge grant=1000 (search from index 3); counter reloaded.
  - All req low → IDLE: grant=0, value_out=0, active=0.
- lock=1 with req=0011, owner 0, DWELL=4:
  - grant held at 0001 for 20 cycles.
  - lock=0 → remaining dwell elapses, then grant=0010.
  - Owner drops req while lock=1 → switch still occurs.
- Assert rst asynchronously mid-cycle during SHOW:
  - outputs go to 0 before the next clock edge.
  - Release with req=1111 → grant=0001 first.
